// File: rtl/noc_pkg.sv
// Shared definitions for the NoC router: port indices and the routing function.
package noc_pkg;

  typedef logic [1:0] port_t;

  localparam port_t P_E = 2'd0;
  localparam port_t P_W = 2'd1;
  localparam port_t P_L = 2'd2;
  localparam int NPORTS = 3;

  // Output port for a flit headed to node d, seen from node id.
  function automatic port_t route_dir(input int d, input int id, input int nodes, input int ring);
    int dE;
    if (d == id || d >= nodes) return P_L;
    if (ring == 0) return (d > id) ? P_E : P_W;
    dE = (d - id + nodes) % nodes;
    return (dE <= nodes / 2) ? P_E : P_W;
  endfunction

  // Cyclic successor in the E -> W -> L -> E priority order.
  function automatic port_t next_port(input port_t p);
    return (p == P_L) ? P_E : port_t'(p + 2'd1);
  endfunction

endpackage

// File: rtl/noc_fifo.sv
// Input FIFO with a registered head stage: the arbiter only ever sees the
// head register, and the count covers both the storage and the head.
module noc_fifo
  import noc_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 32,
  parameter int ADDWIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             read,
  output logic             headValid,
  output logic [WIDTH-1:0] headData,
  output logic             full,
  output logic             almostFull,
  output logic             drop
);

  localparam logic [ADDWIDTH:0] FULLCNT = (ADDWIDTH + 1)'(DEPTH);
  localparam logic [ADDWIDTH:0] AFCNT   = (ADDWIDTH + 1)'(DEPTH - 2);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [ADDWIDTH-1:0] wrPtr, rdPtr;
  logic [ADDWIDTH:0]   count, memCount;
  logic                push, pop, loadHead;

  assign push       = write && !full;
  assign pop        = read && headValid;
  assign loadHead   = (memCount != '0) && (!headValid || pop);
  assign full       = (count == FULLCNT);
  assign almostFull = (count >= AFCNT);
  assign drop       = write && full;

  // Storage array; contents need no reset because the pointers gate every read.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= dataIn;
  end

  // Pointers, occupancy counts and the head register refilled from storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      memCount  <= '0;
      headValid <= 1'b0;
      headData  <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (loadHead) begin
        headData  <= mem[rdPtr];
        rdPtr     <= rdPtr + 1'b1;
        headValid <= 1'b1;
      end else if (pop) begin
        headValid <= 1'b0;
      end
      memCount <= memCount + (ADDWIDTH + 1)'(push) - (ADDWIDTH + 1)'(loadHead);
      count    <= count + (ADDWIDTH + 1)'(push) - (ADDWIDTH + 1)'(pop);
    end
  end

endmodule

// File: rtl/noc_ring_router.sv
// Three-port (E/W/L) chain/ring router: per-input FIFO, per-output round-robin
// arbiter gated by downstream almost-full, and a registered output stage.
module noc_ring_router
  import noc_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 32,
  parameter int ADDWIDTH = 5,
  parameter int NODES    = 4,
  parameter int IDW      = 2,
  parameter int NODE_ID  = 0,
  parameter int RING     = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             writeE,
  input  logic             writeW,
  input  logic             writeL,
  input  logic [WIDTH-1:0] dataInE,
  input  logic [WIDTH-1:0] dataInW,
  input  logic [WIDTH-1:0] dataInL,
  output logic             fullE,
  output logic             fullW,
  output logic             fullL,
  output logic             almost_fullE,
  output logic             almost_fullW,
  output logic             almost_fullL,
  output logic [WIDTH-1:0] dataOutE,
  output logic [WIDTH-1:0] dataOutW,
  output logic [WIDTH-1:0] dataOutL,
  output logic             writeOutE,
  output logic             writeOutW,
  output logic             writeOutL,
  input  logic             readFullE,
  input  logic             readFullW,
  input  logic             readFullL,
  input  logic             read_almostfullE,
  input  logic             read_almostfullW,
  input  logic             read_almostfullL,
  output logic             drop_err,
  output logic             route_err
);

  logic [2:0]       wrIn, fifoFull, fifoAf, fifoDrop, headValid, pop, badDest;
  logic [2:0]       outBlocked, grantAny, writeOutR;
  logic [WIDTH-1:0] dataInA [3];
  logic [WIDTH-1:0] headData [3];
  logic [WIDTH-1:0] dataOutR [3];
  logic [IDW-1:0]   destId [3];
  port_t            dir [3];
  port_t            grantSrc [3];
  port_t            rrPtr [3];
  port_t            cand;

  assign wrIn       = {writeL, writeW, writeE};
  assign outBlocked = {read_almostfullL, read_almostfullW, read_almostfullE};
  assign dataInA[P_E] = dataInE;
  assign dataInA[P_W] = dataInW;
  assign dataInA[P_L] = dataInL;

  for (genvar i = 0; i < NPORTS; i++) begin : gPort
    noc_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDWIDTH(ADDWIDTH)) uFifo (
      .clk       (clk),
      .reset     (reset),
      .write     (wrIn[i]),
      .dataIn    (dataInA[i]),
      .read      (pop[i]),
      .headValid (headValid[i]),
      .headData  (headData[i]),
      .full      (fifoFull[i]),
      .almostFull(fifoAf[i]),
      .drop      (fifoDrop[i])
    );
    assign destId[i]  = headData[i][WIDTH-1 -: IDW];
    assign dir[i]     = route_dir(int'(destId[i]), NODE_ID, NODES, RING);
    assign badDest[i] = headValid[i] && (int'(destId[i]) >= NODES);
  end

  // Round-robin grant per output, scanning inputs from that output's pointer.
  always_comb begin
    grantAny = '0;
    pop      = '0;
    cand     = P_E;
    for (int o = 0; o < NPORTS; o++) begin
      grantSrc[o] = P_E;
      for (int k = 0; k < NPORTS; k++) begin
        cand = port_t'((int'(rrPtr[o]) + k) % NPORTS);
        if (!grantAny[o] && !outBlocked[o] && headValid[cand] && dir[cand] == port_t'(o)) begin
          grantAny[o] = 1'b1;
          grantSrc[o] = cand;
          pop[cand]   = 1'b1;
        end
      end
    end
  end

  // Output registers and pointer advance; a reset drops everything in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      writeOutR <= '0;
      for (int o = 0; o < NPORTS; o++) begin
        dataOutR[o] <= '0;
        rrPtr[o]    <= P_E;
      end
    end else begin
      writeOutR <= grantAny;
      for (int o = 0; o < NPORTS; o++) begin
        if (grantAny[o]) begin
          dataOutR[o] <= headData[grantSrc[o]];
          rrPtr[o]    <= next_port(grantSrc[o]);
        end
      end
    end
  end

  // Sticky error flags for dropped writes and out-of-range destinations.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_err  <= 1'b0;
      route_err <= 1'b0;
    end else begin
      drop_err  <= drop_err | (|fifoDrop);
      route_err <= route_err | (|badDest);
    end
  end

  assign fullE        = fifoFull[P_E];
  assign fullW        = fifoFull[P_W];
  assign fullL        = fifoFull[P_L];
  assign almost_fullE = fifoAf[P_E];
  assign almost_fullW = fifoAf[P_W];
  assign almost_fullL = fifoAf[P_L];
  assign writeOutE    = writeOutR[P_E];
  assign writeOutW    = writeOutR[P_W];
  assign writeOutL    = writeOutR[P_L];
  assign dataOutE     = dataOutR[P_E];
  assign dataOutW     = dataOutR[P_W];
  assign dataOutL     = dataOutR[P_L];

  // The almost-full margin must keep a full downstream FIFO from being written.
  assert property (@(posedge clk) disable iff (reset) !(writeOutE && readFullE));
  assert property (@(posedge clk) disable iff (reset) !(writeOutW && readFullW));
  assert property (@(posedge clk) disable iff (reset) !(writeOutL && readFullL));

endmodule

// File: tb/tb_noc_ring_router.sv
// Directed bench for noc_ring_router: three instances (chain node 1, ring node 3,
// ring node 3 with a 3-bit id field and 5 nodes) share the same input stimulus.
module tb_noc_ring_router;
  import noc_pkg::*;

  localparam int AE = 0, AW = 1, AL = 2, RE = 3, RW = 4, RL = 5, XE = 6, XW = 7, XL = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr [3];
  logic [15:0] din [3];
  logic        ra [3];
  logic        rf [3];
  logic        wo [9];
  logic [15:0] dOut [9];
  logic        fl [9];
  logic        af [9];
  logic        dropV [3];
  logic        routeV [3];
  int          passCount = 0;
  int          totalCount = 0;

  always #5 clk = ~clk;

  noc_ring_router #(.WIDTH(16), .DEPTH(32), .ADDWIDTH(5), .NODES(4), .IDW(2), .NODE_ID(1), .RING(0)) dutA (
    .clk(clk), .reset(reset),
    .writeE(wr[0]), .writeW(wr[1]), .writeL(wr[2]),
    .dataInE(din[0]), .dataInW(din[1]), .dataInL(din[2]),
    .fullE(fl[0]), .fullW(fl[1]), .fullL(fl[2]),
    .almost_fullE(af[0]), .almost_fullW(af[1]), .almost_fullL(af[2]),
    .dataOutE(dOut[0]), .dataOutW(dOut[1]), .dataOutL(dOut[2]),
    .writeOutE(wo[0]), .writeOutW(wo[1]), .writeOutL(wo[2]),
    .readFullE(rf[0]), .readFullW(rf[1]), .readFullL(rf[2]),
    .read_almostfullE(ra[0]), .read_almostfullW(ra[1]), .read_almostfullL(ra[2]),
    .drop_err(dropV[0]), .route_err(routeV[0]));

  noc_ring_router #(.WIDTH(16), .DEPTH(32), .ADDWIDTH(5), .NODES(4), .IDW(2), .NODE_ID(3), .RING(1)) dutR (
    .clk(clk), .reset(reset),
    .writeE(wr[0]), .writeW(wr[1]), .writeL(wr[2]),
    .dataInE(din[0]), .dataInW(din[1]), .dataInL(din[2]),
    .fullE(fl[3]), .fullW(fl[4]), .fullL(fl[5]),
    .almost_fullE(af[3]), .almost_fullW(af[4]), .almost_fullL(af[5]),
    .dataOutE(dOut[3]), .dataOutW(dOut[4]), .dataOutL(dOut[5]),
    .writeOutE(wo[3]), .writeOutW(wo[4]), .writeOutL(wo[5]),
    .readFullE(rf[0]), .readFullW(rf[1]), .readFullL(rf[2]),
    .read_almostfullE(ra[0]), .read_almostfullW(ra[1]), .read_almostfullL(ra[2]),
    .drop_err(dropV[1]), .route_err(routeV[1]));

  noc_ring_router #(.WIDTH(16), .DEPTH(32), .ADDWIDTH(5), .NODES(5), .IDW(3), .NODE_ID(3), .RING(1)) dutX (
    .clk(clk), .reset(reset),
    .writeE(wr[0]), .writeW(wr[1]), .writeL(wr[2]),
    .dataInE(din[0]), .dataInW(din[1]), .dataInL(din[2]),
    .fullE(fl[6]), .fullW(fl[7]), .fullL(fl[8]),
    .almost_fullE(af[6]), .almost_fullW(af[7]), .almost_fullL(af[8]),
    .dataOutE(dOut[6]), .dataOutW(dOut[7]), .dataOutL(dOut[8]),
    .writeOutE(wo[6]), .writeOutW(wo[7]), .writeOutL(wo[8]),
    .readFullE(rf[0]), .readFullW(rf[1]), .readFullL(rf[2]),
    .read_almostfullE(ra[0]), .read_almostfullW(ra[1]), .read_almostfullL(ra[2]),
    .drop_err(dropV[2]), .route_err(routeV[2]));

  // Clear all stimulus, pulse reset, and return just after a rising edge.
  task automatic doReset();
    for (int p = 0; p < 3; p++) begin
      wr[p] = 1'b0; din[p] = '0; ra[p] = 1'b0; rf[p] = 1'b0;
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Write one flit on the given input, then wait until its output register has loaded.
  task automatic sendFlit(input int port, input logic [15:0] data);
    wr[port] = 1'b1; din[port] = data;
    @(posedge clk); #1;
    wr[port] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    for (int p = 0; p < 3; p++) begin
      totalCount++; if (wo[p] !== 1'b0) $display("FAIL reset_writeOut%0d got %b want 0", p, wo[p]); else passCount++;
      totalCount++; if (dOut[p] !== 16'h0) $display("FAIL reset_dataOut%0d got %h want 0000", p, dOut[p]); else passCount++;
      totalCount++; if (fl[p] !== 1'b0) $display("FAIL reset_full%0d got %b want 0", p, fl[p]); else passCount++;
      totalCount++; if (af[p] !== 1'b0) $display("FAIL reset_afull%0d got %b want 0", p, af[p]); else passCount++;
    end
    totalCount++; if (dropV[0] !== 1'b0) $display("FAIL reset_drop_err got %b want 0", dropV[0]); else passCount++;
    totalCount++; if (routeV[0] !== 1'b0) $display("FAIL reset_route_err got %b want 0", routeV[0]); else passCount++;
    doReset();
  endtask

  task automatic test_local_route();
    wr[P_L] = 1'b1; din[P_L] = 16'hC0A5;
    @(posedge clk); #1;
    wr[P_L] = 1'b0;
    @(posedge clk); #1;
    totalCount++; if (wo[AE] !== 1'b0) $display("FAIL lat_early_E got %b want 0", wo[AE]); else passCount++;
    @(posedge clk); #1;
    totalCount++; if (wo[AE] !== 1'b1) $display("FAIL lat_E_write got %b want 1", wo[AE]); else passCount++;
    totalCount++; if (dOut[AE] !== 16'hC0A5) $display("FAIL lat_E_data got %h want c0a5", dOut[AE]); else passCount++;
    totalCount++; if (wo[AW] !== 1'b0 || wo[AL] !== 1'b0) $display("FAIL lat_other got W=%b L=%b want 0 0", wo[AW], wo[AL]); else passCount++;
    sendFlit(P_L, 16'h0123);
    totalCount++; if (wo[AW] !== 1'b1 || dOut[AW] !== 16'h0123) $display("FAIL route_W got %b/%h want 1/0123", wo[AW], dOut[AW]); else passCount++;
    sendFlit(P_E, 16'h4321);
    totalCount++; if (wo[AL] !== 1'b1 || dOut[AL] !== 16'h4321) $display("FAIL route_L got %b/%h want 1/4321", wo[AL], dOut[AL]); else passCount++;
    totalCount++; if (wo[AE] !== 1'b0) $display("FAIL route_L_notE got %b want 0", wo[AE]); else passCount++;
  endtask

  task automatic test_round_robin();
    logic [15:0] e;
    doReset();
    for (int k = 0; k < 3; k++) begin
      wr[P_E] = 1'b1; din[P_E] = 16'h4E00 + 16'(k);
      wr[P_W] = 1'b1; din[P_W] = 16'h4B00 + 16'(k);
      @(posedge clk); #1;
    end
    wr[P_E] = 1'b0; wr[P_W] = 1'b0;
    for (int j = 0; j < 6; j++) begin
      e = ((j % 2) == 0) ? 16'h4E00 : 16'h4B00;
      e = e + 16'(j / 2);
      totalCount++; if (wo[AL] !== 1'b1 || dOut[AL] !== e) $display("FAIL rr2_slot%0d got %b/%h want 1/%h", j, wo[AL], dOut[AL], e); else passCount++;
      @(posedge clk); #1;
    end
    doReset();
    for (int k = 0; k < 2; k++) begin
      wr[P_E] = 1'b1; din[P_E] = 16'h4E00 + 16'(k);
      wr[P_W] = 1'b1; din[P_W] = 16'h4B00 + 16'(k);
      wr[P_L] = 1'b1; din[P_L] = 16'h4C00 + 16'(k);
      @(posedge clk); #1;
    end
    wr[P_E] = 1'b0; wr[P_W] = 1'b0; wr[P_L] = 1'b0;
    @(posedge clk); #1;
    for (int j = 0; j < 6; j++) begin
      case (j % 3)
        0:       e = 16'h4E00;
        1:       e = 16'h4B00;
        default: e = 16'h4C00;
      endcase
      e = e + 16'(j / 3);
      totalCount++; if (wo[AL] !== 1'b1 || dOut[AL] !== e) $display("FAIL rr3_slot%0d got %b/%h want 1/%h", j, wo[AL], dOut[AL], e); else passCount++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic sawOut;
    int   waitCnt;
    doReset();
    ra[P_E] = 1'b1;
    sawOut = 1'b0;
    for (int k = 0; k < 40; k++) begin
      wr[P_L] = 1'b1; din[P_L] = 16'hC000 | 16'(k);
      @(negedge clk);
      if (wo[AE]) sawOut = 1'b1;
      if (k == 29) begin totalCount++; if (af[AL] !== 1'b0) $display("FAIL bp_afull29 got %b want 0", af[AL]); else passCount++; end
      if (k == 30) begin totalCount++; if (af[AL] !== 1'b1) $display("FAIL bp_afull30 got %b want 1", af[AL]); else passCount++; end
      if (k == 31) begin totalCount++; if (fl[AL] !== 1'b0) $display("FAIL bp_full31 got %b want 0", fl[AL]); else passCount++; end
      if (k == 32) begin
        totalCount++; if (fl[AL] !== 1'b1) $display("FAIL bp_full32 got %b want 1", fl[AL]); else passCount++;
        totalCount++; if (dropV[0] !== 1'b0) $display("FAIL bp_drop32 got %b want 0", dropV[0]); else passCount++;
      end
      if (k == 33) begin totalCount++; if (dropV[0] !== 1'b1) $display("FAIL bp_drop33 got %b want 1", dropV[0]); else passCount++; end
      @(posedge clk); #1;
    end
    wr[P_L] = 1'b0;
    totalCount++; if (sawOut !== 1'b0) $display("FAIL bp_held got %b want 0", sawOut); else passCount++;
    ra[P_E] = 1'b0;
    waitCnt = 0;
    @(negedge clk);
    while (!wo[AE] && waitCnt < 10) begin
      @(negedge clk);
      waitCnt++;
    end
    totalCount++; if (wo[AE] !== 1'b1) $display("FAIL bp_drain_start got %b want 1 within 10 cycles", wo[AE]); else passCount++;
    for (int j = 0; j < 32; j++) begin
      totalCount++;
      if (wo[AE] !== 1'b1 || dOut[AE] !== (16'hC000 | 16'(j)))
        $display("FAIL bp_drain%0d got %b/%h want 1/%h", j, wo[AE], dOut[AE], 16'hC000 | 16'(j));
      else passCount++;
      @(negedge clk);
    end
    totalCount++; if (wo[AE] !== 1'b0) $display("FAIL bp_drain_end got %b want 0", wo[AE]); else passCount++;
  endtask

  task automatic test_ring();
    doReset();
    sendFlit(P_L, 16'h0011);
    totalCount++; if (wo[RE] !== 1'b1 || dOut[RE] !== 16'h0011) $display("FAIL ring_d0_E got %b/%h want 1/0011", wo[RE], dOut[RE]); else passCount++;
    totalCount++; if (wo[RW] !== 1'b0) $display("FAIL ring_d0_notW got %b want 0", wo[RW]); else passCount++;
    sendFlit(P_L, 16'h4022);
    totalCount++; if (wo[RE] !== 1'b1 || dOut[RE] !== 16'h4022) $display("FAIL ring_d1_tieE got %b/%h want 1/4022", wo[RE], dOut[RE]); else passCount++;
    sendFlit(P_L, 16'h8033);
    totalCount++; if (wo[RW] !== 1'b1 || dOut[RW] !== 16'h8033) $display("FAIL ring_d2_W got %b/%h want 1/8033", wo[RW], dOut[RW]); else passCount++;
    totalCount++; if (routeV[2] !== 1'b0) $display("FAIL ring_rerr_clear got %b want 0", routeV[2]); else passCount++;
    sendFlit(P_L, 16'hE055);
    totalCount++; if (wo[XL] !== 1'b1 || dOut[XL] !== 16'hE055) $display("FAIL ring_d7_L got %b/%h want 1/e055", wo[XL], dOut[XL]); else passCount++;
    totalCount++; if (routeV[2] !== 1'b1) $display("FAIL ring_rerr_set got %b want 1", routeV[2]); else passCount++;
    totalCount++; if (wo[RL] !== 1'b1 || routeV[1] !== 1'b0) $display("FAIL ring_d3_self got %b/%b want 1/0", wo[RL], routeV[1]); else passCount++;
  endtask

  task automatic test_mid_reset();
    logic sawAny;
    doReset();
    ra[P_E] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wr[P_L] = 1'b1; din[P_L] = 16'hC100 + 16'(k);
      wr[P_E] = 1'b1; din[P_E] = 16'h4200 + 16'(k);
      @(posedge clk); #1;
    end
    wr[P_L] = 1'b0; wr[P_E] = 1'b0;
    @(negedge clk);
    totalCount++; if (wo[AL] !== 1'b1 || dOut[AL] !== 16'h4207) $display("FAIL mr_pre got %b/%h want 1/4207", wo[AL], dOut[AL]); else passCount++;
    reset = 1'b1;
    #1;
    totalCount++; if (wo[AL] !== 1'b0 || dOut[AL] !== 16'h0) $display("FAIL mr_outL got %b/%h want 0/0000", wo[AL], dOut[AL]); else passCount++;
    totalCount++; if (dOut[AE] !== 16'h0 || wo[AE] !== 1'b0) $display("FAIL mr_outE got %b/%h want 0/0000", wo[AE], dOut[AE]); else passCount++;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    ra[P_E] = 1'b0;
    sawAny = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (wo[AE] || wo[AW] || wo[AL]) sawAny = 1'b1;
    end
    totalCount++; if (sawAny !== 1'b0) $display("FAIL mr_stale got %b want 0", sawAny); else passCount++;
    totalCount++; if (dropV[0] !== 1'b0 || fl[AL] !== 1'b0) $display("FAIL mr_flags got %b/%b want 0/0", dropV[0], fl[AL]); else passCount++;
  endtask

  // Hard stop in case any wait above never completes.
  initial begin
    #200000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int p = 0; p < 3; p++) begin
      wr[p] = 1'b0; din[p] = '0; ra[p] = 1'b0; rf[p] = 1'b0;
    end
    test_reset();
    test_local_route();
    test_round_robin();
    test_backpressure();
    test_ring();
    test_mid_reset();
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
